bcd_serial_add_ctrl: RTL and testbench

BCD_SERIAL_ADD_CTRL -- requirements
Module: bcd_serial_add_ctrl

---
 rtl/bcd_serial_add_ctrl.sv | 146 ++++++++++++++
 tb/tb_bcd_serial_add_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial BCD adder controller: one 4-bit BCD adder stage, one digit per RUN cycle.
// Optional macro BCD_SUB_EN adds a `sub` port for ten's-complement subtraction.
module bcd_serial_add_ctrl #(
  parameter int DIGIT_NUM = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [4*DIGIT_NUM-1:0] A,
  input  logic [4*DIGIT_NUM-1:0] B,
  input  logic                   Cin,
`ifdef BCD_SUB_EN
  input  logic                   sub,
`endif
  output logic                   busy,
  output logic                   done,
  output logic [4*DIGIT_NUM-1:0] S,
  output logic                   Cout,
  output logic                   err,
  output logic [1:0]             state_dbg
);

  localparam int W  = 4 * DIGIT_NUM;
  localparam int CW = (DIGIT_NUM > 1) ? $clog2(DIGIT_NUM) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Handshake: start is sampled only in IDLE (launch not pending); operands are
  // captured on that edge, RUN follows one cycle later, and done pulses for one
  // cycle when S/Cout/err change. start seen at any other time is dropped.
  state_t          state, state_nxt;
  logic            launch;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    a_sh, b_sh, s_sh;
  logic            carry;
  logic            err_acc;

  logic [W-1:0]    b_lat;
  logic            cin_lat;
  logic            err_in;
  logic [4:0]      t, t6;
  logic            gt9;
  logic [3:0]      dig_s;
  logic [W+3:0]    s_cat;
  logic [W-1:0]    s_nxt;
  logic            last;

  // Operand conditioning at capture time: range check on raw digits, then
  // optional nine's complement of B.
  always_comb begin
    b_lat  = B;
    err_in = 1'b0;
    for (int i = 0; i < DIGIT_NUM; i++) begin
      if (A[4*i +: 4] > 4'd9 || B[4*i +: 4] > 4'd9) err_in = 1'b1;
`ifdef BCD_SUB_EN
      if (sub) b_lat[4*i +: 4] = 4'd9 - B[4*i +: 4];
`endif
    end
  end

`ifdef BCD_SUB_EN
  assign cin_lat = sub ? 1'b1 : Cin;
`else
  assign cin_lat = Cin;
`endif

  // Single BCD digit stage on the low digit of the shifting operands.
  always_comb begin
    t     = {1'b0, a_sh[3:0]} + {1'b0, b_sh[3:0]} + {4'b0, carry};
    gt9   = (t > 5'd9);
    t6    = t + 5'd6;
    dig_s = gt9 ? t6[3:0] : t[3:0];
    s_cat = {dig_s, s_sh};
    s_nxt = s_cat[W+3:4];
    last  = (cnt == CW'(DIGIT_NUM - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (launch) state_nxt = RUN;
      RUN:     if (last)   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign state_dbg = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      launch  <= 1'b0;
      cnt     <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
      s_sh    <= '0;
      carry   <= 1'b0;
      err_acc <= 1'b0;
      S       <= '0;
      Cout    <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (launch) begin
            launch <= 1'b0;
          end else if (start) begin
            launch  <= 1'b1;
            a_sh    <= A;
            b_sh    <= b_lat;
            carry   <= cin_lat;
            cnt     <= '0;
            err_acc <= err_in;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 4;
          b_sh  <= b_sh >> 4;
          s_sh  <= s_nxt;
          carry <= gt9;
          if (last) begin
            // Results become visible together, on entry to DONE.
            S    <= s_nxt;
            Cout <= gt9;
            err  <= err_acc;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Bench for bcd_serial_add_ctrl: directed vectors, random vectors, reset abort.
// Define BCD_SUB_EN to also exercise subtraction.
module tb_bcd_serial_add_ctrl;

  localparam int N = 8;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         reset, start, Cin;
  logic [W-1:0] A, B, S;
  logic         busy, done, Cout, err;
  logic [1:0]   state_dbg;
`ifdef BCD_SUB_EN
  logic         sub = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  logic [W+1:0] exp_q[$];

  bcd_serial_add_ctrl #(.DIGIT_NUM(N)) dut (
    .clk(clk), .reset(reset), .start(start), .A(A), .B(B), .Cin(Cin),
`ifdef BCD_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .S(S), .Cout(Cout), .err(err), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Reference: returns {err, cout, s}.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub_i);
    logic [W-1:0] s;
    logic         c, e;
    logic [3:0]   ad, bd;
    int           t;
    s = '0; e = 1'b0; c = sub_i ? 1'b1 : cin;
    for (int i = 0; i < N; i++) begin
      ad = a[4*i +: 4];
      bd = b[4*i +: 4];
      if (ad > 9 || bd > 9) e = 1'b1;
      if (sub_i) bd = 4'd9 - bd;
      t = int'(ad) + int'(bd) + int'(c);
      if (t > 9) begin s[4*i +: 4] = 4'((t + 6) % 16); c = 1'b1; end
      else       begin s[4*i +: 4] = 4'(t);            c = 1'b0; end
    end
    return {e, c, s};
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub_i, input logic poke, input logic [W+1:0] exp_in,
                        input string name);
    logic [W+1:0] exp, got;
    logic [W-1:0] s_before;
    int           lat, extra;
    bit           stable, busy_ok;
    exp_q.push_back(exp_in);
    @(negedge clk);
    A = a; B = b; Cin = cin; start = 1'b1;
`ifdef BCD_SUB_EN
    sub = sub_i;
`endif
    s_before = S;
    @(posedge clk);
    #1 start = 1'b0; A = $urandom; B = $urandom; Cin = 1'($urandom_range(0, 1));
    lat = 0; stable = 1; busy_ok = 1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin lat = i; break; end
      if (S !== s_before) stable = 0;
      if (busy !== (i >= 2)) busy_ok = 0;
      if (poke && i == 4) begin
        start = 1'b1; A = 32'h11111111; B = 32'h22222222;
        @(posedge clk);
        #1 start = 1'b0;
      end
    end
    checks++;
    if (lat != N + 2) begin
      errors++; $display("FAIL %s latency: got %0d cycles expected %0d", name, lat, N + 2);
    end
    exp = exp_q.pop_front();
    got = {err, Cout, S};
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL %s result {err,cout,s}: got %h expected %h", name, got, exp);
    end
    checks++;
    if (!stable || !busy_ok) begin
      errors++; $display("FAIL %s run phase: s_stable=%0d busy_ok=%0d expected 1 1", name, stable, busy_ok);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL %s pulse: done=%b busy=%b expected 0 0", name, done, busy);
    end
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || {err, Cout, S} !== exp) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++; $display("FAIL %s hold: got %0d bad idle cycles expected 0", name, extra);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, Cout, err} !== 4'b0 || S !== '0 || state_dbg !== 2'd0) begin
      errors++; $display("FAIL reset: got busy=%b done=%b S=%h Cout=%b err=%b st=%0d expected all 0",
                         busy, done, S, Cout, err, state_dbg);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || state_dbg !== 2'd0) begin
      errors++; $display("FAIL post_reset idle: got busy=%b done=%b st=%0d expected 0 0 0", busy, done, state_dbg);
    end
  endtask

  task automatic test_add_basic();
    run_op(32'h00000123, 32'h00000456, 1'b0, 1'b0, 1'b0, {1'b0, 1'b0, 32'h00000579}, "add_basic");
  endtask

  task automatic test_ripple();
    run_op(32'h99999999, 32'h00000001, 1'b0, 1'b0, 1'b0, {1'b0, 1'b1, 32'h00000000}, "ripple");
  endtask

  task automatic test_ignore_start();
    run_op(32'h00000005, 32'h00000005, 1'b1, 1'b0, 1'b1, {1'b0, 1'b0, 32'h00000011}, "ignore_start");
  endtask

  task automatic test_err();
    run_op(32'h0000000A, 32'h00000001, 1'b0, 1'b0, 1'b0, {1'b1, 1'b0, 32'h00000011}, "err_digit");
  endtask

  task automatic test_reset_mid_run();
    int dones;
    @(negedge clk);
    A = 32'h12345678; B = 32'h11111111; Cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, Cout, err} !== 4'b0 || S !== '0 || state_dbg !== 2'd0) begin
      errors++; $display("FAIL mid_run_reset: got busy=%b done=%b S=%h Cout=%b err=%b expected all 0",
                         busy, done, S, Cout, err);
    end
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (done !== 1'b0) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++; $display("FAIL abort_no_done: got %0d done cycles expected 0", dones);
    end
    run_op(32'h12345678, 32'h11111111, 1'b0, 1'b0, 1'b0, {1'b0, 1'b0, 32'h23456789}, "restart");
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    logic         c;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < N; i++) begin
        a[4*i +: 4] = 4'($urandom_range(0, 9));
        b[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      c = 1'($urandom_range(0, 1));
      run_op(a, b, c, 1'b0, 1'b0, model(a, b, c, 1'b0), "random_add");
    end
  endtask

`ifdef BCD_SUB_EN
  task automatic test_sub();
    run_op(32'h00000500, 32'h00000123, 1'b0, 1'b1, 1'b0, {1'b0, 1'b1, 32'h00000377}, "sub_pos");
    run_op(32'h00000123, 32'h00000500, 1'b1, 1'b1, 1'b0, {1'b0, 1'b0, 32'h99999623}, "sub_neg");
    run_op(32'h00000042, 32'h00000042, 1'b0, 1'b1, 1'b0, model(32'h42, 32'h42, 1'b0, 1'b1), "sub_zero");
  endtask
`endif

  initial begin
    test_reset();
    test_add_basic();
    test_ripple();
    test_ignore_start();
    test_err();
    test_reset_mid_run();
    test_random();
`ifdef BCD_SUB_EN
    test_sub();
`endif
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
